// File: rtl/cpu_types_pkg.sv
// Shared integer-datapath types.
//   word_t       : 32-bit architectural word
//   mdu_op_t     : RV32M multiply/divide operation, encoded in funct3 order
//   mdu_state_t  : multiply/divide unit FSM state, with IDLE/COMPUTE/FINISH/DONE constants
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } mdu_op_t;

  typedef logic [1:0] mdu_state_t;

  localparam mdu_state_t IDLE    = 2'd0;
  localparam mdu_state_t COMPUTE = 2'd1;
  localparam mdu_state_t FINISH  = 2'd2;
  localparam mdu_state_t DONE    = 2'd3;

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
// Shifts remainder:quotient left by one, trial-subtracts the divisor and
// keeps the difference (setting the new quotient bit) when it does not borrow.
//   rem_in / quo_in   : current partial remainder and quotient/dividend bits
//   divisor           : divisor magnitude
//   rem_out / quo_out : values after this step
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] diff;
  logic           fits;

  // rem_in < divisor always holds, so the shifted value is below 2*divisor and
  // a non-borrowing difference always fits back into WIDTH bits.
  assign rem_shift = {rem_in, quo_in[WIDTH-1]};
  assign diff      = rem_shift - {1'b0, divisor};
  assign fits      = ~diff[WIDTH];

  assign rem_out = fits ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quo_out = {quo_in[WIDTH-2:0], fits};

endmodule

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit (radix-2 shift-add multiply, restoring
// divide, both on magnitudes with sign correction in FINISH).
// Ports:
//   CLK, RST   : clock (rising edge), asynchronous active-high reset
//   start, op  : request valid (sampled in IDLE only) and operation
//   A, B       : rs1 / rs2 operands
//   flush      : abandon the in-flight operation
//   busy       : high while an accepted operation is in flight, through DONE
//   done       : one-cycle pulse, result valid
//   result     : held from done until the next accepted start
// Build option: define MDU_EARLY_OUT_EN to let multiplies leave COMPUTE once
// the remaining multiplier bits are all zero.
//
// state   | meaning
// IDLE    | waiting for start; special cases resolved here
// COMPUTE | one multiply/divide bit per cycle
// FINISH  | sign correction and word select into result
// DONE    | done pulse, back to IDLE
module mdu
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  mdu_op_t          op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  mdu_state_t         state;
  mdu_op_t            op_q;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod;    // product, or remainder:quotient for divides
  logic [WIDTH-1:0]   opb;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   mplier;  // multiplier magnitude, consumed LSB first
  logic               a_neg;
  logic               b_neg;

  // request decode
  logic             a_signed, b_signed, a_neg_d, b_neg_d;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             is_div, div_zero, div_ovf, mul_skip;
  logic [WIDTH-1:0] special_res;

  assign a_signed = op inside {MUL, MULH, MULHSU, DIV, REM};
  assign b_signed = op inside {MUL, MULH, DIV, REM};
  assign a_neg_d  = a_signed & A[WIDTH-1];
  assign b_neg_d  = b_signed & B[WIDTH-1];
  assign a_mag    = a_neg_d ? -A : A;
  assign b_mag    = b_neg_d ? -B : B;

  assign is_div   = op[2];
  assign div_zero = is_div && (B == '0);
  assign div_ovf  = (op == DIV || op == REM) &&
                    (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);

  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = op[1] ? A : '1;
    else if (div_ovf)
      special_res = op[1] ? '0 : A;
  end

  // one iteration of either algorithm
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, step_next, prod_d;
  logic [WIDTH-1:0]   div_rem, div_quo;
  logic               last_step;

  assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} +
                    (mplier[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, prod[WIDTH-1:1]};

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (prod[2*WIDTH-1:WIDTH]),
    .quo_in  (prod[WIDTH-1:0]),
    .divisor (opb),
    .rem_out (div_rem),
    .quo_out (div_quo)
  );

  assign step_next = op_q[2] ? {div_rem, div_quo} : mul_next;

`ifdef MDU_EARLY_OUT_EN
  logic early_out;
  // After this step no multiplier bits remain set: the partial product only
  // lacks the right shifts the skipped cycles would have applied.
  assign early_out = ~op_q[2] && (mplier[WIDTH-1:1] == '0);
  assign last_step = (cnt == CNT_W'(1)) || early_out;
  assign prod_d    = early_out ? (step_next >> (cnt - CNT_W'(1))) : step_next;
  assign mul_skip  = ~is_div && (B == '0);
`else
  assign last_step = (cnt == CNT_W'(1));
  assign prod_d    = step_next;
  assign mul_skip  = 1'b0;
`endif

  // sign correction and word select
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   fin_res;

  assign mul_res = (a_neg ^ b_neg) ? -prod : prod;

  always_comb begin
    fin_res = '0;
    case (op_q)
      MUL:                fin_res = mul_res[WIDTH-1:0];
      MULH, MULHSU, MULHU: fin_res = mul_res[2*WIDTH-1:WIDTH];
      DIV, DIVU:          fin_res = (a_neg ^ b_neg) ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
      default:            fin_res = a_neg ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      op_q   <= MUL;
      cnt    <= '0;
      prod   <= '0;
      opb    <= '0;
      mplier <= '0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !flush) begin
            op_q   <= op;
            a_neg  <= a_neg_d;
            b_neg  <= b_neg_d;
            cnt    <= CNT_W'(WIDTH);
            opb    <= is_div ? b_mag : a_mag;
            mplier <= b_mag;
            prod   <= is_div ? {{WIDTH{1'b0}}, a_mag} : '0;
            if (div_zero || div_ovf) begin
              result <= special_res;
              state  <= DONE;
            end else if (mul_skip) begin
              state <= FINISH;
            end else begin
              state <= COMPUTE;
            end
          end
        end
        COMPUTE: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            cnt    <= cnt - CNT_W'(1);
            mplier <= mplier >> 1;
            prod   <= prod_d;
            if (last_step)
              state <= FINISH;
          end
        end
        FINISH: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            result <= fin_res;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mdu.sv
// Directed + random bench for mdu with a result scoreboard and latency checks.
module tb_mdu;
  import cpu_types_pkg::*;

  localparam int L_FULL = 34;
  localparam int L_SPEC = 1;
`ifdef MDU_EARLY_OUT_EN
  localparam int L_MUL_B3 = 4;
  localparam int L_MUL_B0 = 2;
  localparam int L_MUL_RND = 0;
`else
  localparam int L_MUL_B3 = 34;
  localparam int L_MUL_B0 = 34;
  localparam int L_MUL_RND = 34;
`endif

  logic    clk = 1'b0;
  logic    rst, start, flush, busy, done;
  mdu_op_t op;
  word_t   a, b, result;

  int    n_tests = 0;
  int    n_fail  = 0;
  word_t sb_q[$];
  word_t last_exp;

  always #5 clk = ~clk;

  mdu #(.WIDTH(32)) dut (
    .CLK(clk), .RST(rst), .start(start), .op(op), .A(a), .B(b),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic word_t model(input mdu_op_t o, input word_t x, input word_t y);
    longint      sx, sy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = '0;
    case (o)
      MUL:    begin p = 64'(sx * sy); return p[31:0]; end
      MULH:   begin p = 64'(sx * sy); return p[63:32]; end
      MULHSU: begin p = 64'(sx * longint'({32'b0, y})); return p[63:32]; end
      MULHU:  begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      DIV: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        p = 64'(sx / sy); return p[31:0];
      end
      REM: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        p = 64'(sx % sy); return p[31:0];
      end
      DIVU:    return (y == 0) ? 32'hFFFF_FFFF : x / y;
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Issue one op, wait (bounded) for done, compare result and latency.
  // exp_lat <= 0 skips the latency check; poke > 0 pulses a stray start with
  // different operands in that cycle.
  task automatic run_op(input string tag, input mdu_op_t o, input word_t x, input word_t y,
                        input int exp_lat, input bit chk_busy, input int poke);
    int cyc;
    bit got;
    sb_q.push_back(model(o, x, y));
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (poke > 0 && cyc == poke) begin
        start = 1'b1; op = MUL; a = 32'h1; b = 32'h1;
      end else if (poke > 0 && cyc == poke + 1) begin
        start = 1'b0;
      end
      if (chk_busy) check({tag, "_busy"}, busy, 1);
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, got, 1);
    if (got) begin
      last_exp = sb_q.pop_front();
      check(tag, result, last_exp);
      if (exp_lat > 0) check({tag, "_lat"}, cyc, exp_lat);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
      if (chk_busy) check({tag, "_busy_after"}, busy, 0);
    end else begin
      void'(sb_q.pop_front());
    end
  endtask

  initial begin
    int hits;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = MUL; a = '0; b = '0;
    last_exp = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    rst = 1'b0;

    run_op("mul_7_m3", MUL, 32'd7, 32'hFFFF_FFFD, L_MUL_B3, 1'b1, 0);
    check("mul_7_m3_val", last_exp, 32'hFFFF_FFEB);
    run_op("mulh",   MULH,   32'h8000_0000, 32'hFFFF_FFFF, L_FULL, 1'b0, 0);
    run_op("mulhu",  MULHU,  32'h8000_0000, 32'hFFFF_FFFF, L_FULL, 1'b0, 0);
    run_op("mulhsu", MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, L_FULL, 1'b0, 0);
    run_op("div_m7_2",  DIV,  32'hFFFF_FFF9, 32'd2, L_FULL, 1'b0, 0);
    run_op("rem_m7_2",  REM,  32'hFFFF_FFF9, 32'd2, L_FULL, 1'b0, 0);
    run_op("divu_100_7", DIVU, 32'd100, 32'd7, L_FULL, 1'b0, 0);
    run_op("remu_100_7", REMU, 32'd100, 32'd7, L_FULL, 1'b0, 0);
    run_op("div_by0",  DIV,  32'd5, 32'd0, L_SPEC, 1'b1, 0);
    run_op("remu_by0", REMU, 32'd5, 32'd0, L_SPEC, 1'b0, 0);
    run_op("div_ovf",  DIV,  32'h8000_0000, 32'hFFFF_FFFF, L_SPEC, 1'b0, 0);
    run_op("rem_ovf",  REM,  32'h8000_0000, 32'hFFFF_FFFF, L_SPEC, 1'b0, 0);
    run_op("mul_9_3",  MUL,  32'd9, 32'd3, L_MUL_B3, 1'b0, 0);
    run_op("mul_9_0",  MUL,  32'd9, 32'd0, L_MUL_B0, 1'b0, 0);
    run_op("start_in_compute", DIVU, 32'd100, 32'd7, L_FULL, 1'b0, 5);

    // flush at cycle 10 of a DIVU
    @(negedge clk);
    op = DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy", busy, 0);
    check("flush_result", result, last_exp);
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) hits++;
    end
    check("flush_no_done", hits, 0);

    // reset mid-COMPUTE
    @(negedge clk);
    op = MUL; a = 32'd11; b = 32'd13; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_op("rnd_mul", mdu_op_t'($urandom_range(0, 3)), $urandom, $urandom, L_MUL_RND, 1'b0, 0);
    for (int i = 0; i < 6; i++)
      run_op("rnd_div", mdu_op_t'($urandom_range(4, 7)), $urandom, $urandom_range(1, 32'hFFFF), 0, 1'b0, 0);

    check("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Iterative RV32M multiply/divide unit.
- The datapath issues a request with `start`, `op`, `A` and `B`; the unit returns a result with a one-cycle `done` pulse.
- Sits beside the ALU as the multi-cycle responder for the integer datapath. The hazard/control unit stalls on `busy`.
- Multiply uses radix-2 shift-add; divide uses restoring division. Both work on magnitudes with sign correction at the end.

Parameters:
- `WIDTH`, 32, operand/result width; must be even, and `CNT_W` = $clog2(`WIDTH`)+1.

Ports:
- `CLK`  in  1  system clock, rising edge
- `RST`  in  1  asynchronous, active-high reset
- `start`  in  1  request valid; sampled only in `IDLE`
- `op`  in  3  `mdu_op_t`: `MUL`, `MULH`, `MULHSU`, `MULHU`, `DIV`, `DIVU`, `REM`, `REMU`
- `A`  in  `WIDTH`  rs1 operand (dividend / multiplicand)
- `B`  in  `WIDTH`  rs2 operand (divisor / multiplier)
- `flush`  in  1  abort the in-flight operation
- `busy`  out  1  high from the cycle after start is accepted until `done`, inclusive of `FINISH`
- `done`  out  1  one-cycle pulse; `result` valid
- `result`  out  `WIDTH`  held from `done` until the next accepted `start`

Behaviour:
- Reset (async, any state): state=`IDLE`; `busy`=0, `done`=0, `result`=0; counter, accumulators and sign flags cleared.
- States: `IDLE`, `COMPUTE`, `FINISH`, `DONE`.
  - `IDLE`: on `start`&~`flush`, latch `op`, |A|, |B|, sign flags (signedness per op: `MULHSU` signs A only; `MULHU`/`DIVU`/`REMU` unsigned), counter=`WIDTH`. Go to `COMPUTE`, or straight to `DONE` for special cases.
  - `COMPUTE`: one bit per cycle.
    - Multiply: if multiplier LSB, add multiplicand into upper half of the 2·`WIDTH` product; shift right.
    - Divide: shift remainder:quotient left, trial-subtract divisor, set the quotient bit if non-negative.
    - Counter decrements; go to `FINISH` when counter reaches 1 on this edge (exactly `WIDTH` cycles).
  - `FINISH`: apply sign correction and select the word.
    - `MUL` takes the low half; `MULH*` take the high half of the 2·`WIDTH` product.
    - Product negated if signs differ (two's complement over 2·`WIDTH` bits).
    - Quotient negated if signs differ; remainder takes the dividend's sign.
    - Register into `result`; go to `DONE`.
  - `DONE`: `done`=1 for this cycle only; return to `IDLE`. `start` in `DONE` is ignored.
- Latency: start seen at edge 0 → `done` high in cycle `WIDTH`+2 (34 for `WIDTH`=32). Special cases: `done` in cycle 1.
- Special cases (decided in `IDLE`, no `COMPUTE`):
  - `DIV`/`DIVU` with B=0 → result all ones.
  - `REM`/`REMU` with B=0 → result=A.
  - `DIV` with A=0x80000000, B=0xFFFFFFFF → 0x80000000.
  - `REM` with the same operands → 0.
- Boundary and arbitration rules:
  - `flush` in any non-`IDLE` state → `IDLE` next cycle, no `done`, `result` unchanged.
  - `flush`&`start` in `IDLE`: `flush` wins.
  - `start` while `busy`: ignored; operands are not re-sampled.
  - Reset mid-operation: immediate return to the reset state.

Optional Feature:
- Macro: `MDU_EARLY_OUT_EN`.
- Defined: in `COMPUTE`, multiply ops go to `FINISH` as soon as the remaining multiplier bits are all zero. Before leaving, the product register is shifted right by the remaining count so the result is bit-identical.
  - Example: B=3 finishes after 2 `COMPUTE` cycles; `done` in cycle 4.
  - Divide ops are unaffected.
- Undefined: fixed `WIDTH`-cycle `COMPUTE` for all ops.

Decomposition:
- `cpu_types_pkg` gains:
  - `mdu_op_t` (3-bit enum; encodings `MUL`=0 … `REMU`=7 in RV32M funct3 order)
  - `mdu_state_t`
  - reuses `word_t`
- One natural sub-module: `mdu_div_step`, a combinational restoring step. Inputs: remainder, quotient, divisor. Outputs: next remainder and quotient. It is reusable for a future radix-4 unrolled version.
- Multiply step stays inline.

Test Plan:
- `MUL` A=7, B=-3 (0xFFFFFFFD) → `result`=0xFFFFFFEB, `done` in cycle 34 without `MDU_EARLY_OUT_EN`; `busy` high cycles 1–34.
- `MULH`/`MULHU`/`MULHSU` with A=0x80000000, B=0xFFFFFFFF → 0x00000000 / 0x7FFFFFFF / 0x80000000.
- `DIV` A=-7, B=2 → 0xFFFFFFFD; `REM` → 0xFFFFFFFF; `DIVU` A=100, B=7 → 14; `REMU` → 2.
- Divide by zero: `DIV` A=5, B=0 → 0xFFFFFFFF and `REMU` → 5, both with `done` in cycle 1. Overflow: `DIV` 0x80000000 / -1 → 0x80000000, `REM` → 0.
- Interruptions:
  - `flush` at cycle 10 of a `DIVU` → no `done`, `busy` low next cycle, `result` keeps its prior value.
  - `start` pulsed during `COMPUTE` → ignored.
  - `RST` asserted mid-`COMPUTE` → all outputs 0 asynchronously.
- With `MDU_EARLY_OUT_EN`: `MUL` A=9, B=3 → 27 with `done` in cycle 4; B=0 → 0 with `done` in cycle 2. Random `MUL`/`MULH*` results match a run without the macro.
